instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/instr_cache_pkg.sv | 33 +++
 rtl/instr_cache_if.sv | 25 ++
 rtl/icache_data_array.sv | 30 +++
 rtl/instr_cache.sv | 159 +++++++++++++++
 tb/tb_instr_cache.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache:
// address-field width derivation, FSM encoding and counter helper.
package instr_cache_pkg;

  localparam int unsigned LINES_DEF = 16;
  localparam int unsigned WORDS_DEF = 4;

  function automatic int unsigned offset_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
    return 32 - index_w(lines) - offset_w(words) - 2;
  endfunction

  localparam int unsigned OFFSET_W = offset_w(WORDS_DEF);
  localparam int unsigned INDEX_W  = index_w(LINES_DEF);
  localparam int unsigned TAG_W    = tag_w(LINES_DEF, WORDS_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and refill-side bus of the instruction cache; the cache
// itself connects through the slave modport.
interface instr_cache_if;
  logic        req_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic        ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [15:0] hit_cnt_o;
  logic [15:0] miss_cnt_o;

  modport slave (
    input  req_i, pc_i, flush_i, mem_ack_i, mem_data_i,
    output instr_o, ready_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output req_i, pc_i, flush_i, mem_ack_i, mem_data_i,
    input  instr_o, ready_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/icache_data_array.sv
// Instruction data storage: LINES x WORDS x 32, asynchronous read and
// synchronous single-word write. Contents are intentionally not reset.
module icache_data_array
  import instr_cache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [index_w(LINES)-1:0]  widx_i,
  input  logic [offset_w(WORDS)-1:0] woff_i,
  input  logic [31:0]                wdata_i,
  input  logic [index_w(LINES)-1:0]  ridx_i,
  input  logic [offset_w(WORDS)-1:0] roff_i,
  output logic [31:0]                rdata_o
);

  logic [31:0] mem_q [LINES][WORDS];

  // refill write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i][woff_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i][roff_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with zero-cycle hits and a two-state
// refill FSM that always loads a full line from word 0.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input logic           clk_i,
  input logic           rst_i,
  instr_cache_if.slave  bus
);

  localparam int unsigned OFF_W = offset_w(WORDS);
  localparam int unsigned IDX_W = index_w(LINES);
  localparam int unsigned TG_W  = tag_w(LINES, WORDS);

  logic [OFF_W-1:0] off_s;
  logic [IDX_W-1:0] idx_s;
  logic [TG_W-1:0]  tag_s;
  logic             pc_unused;

  assign off_s     = bus.pc_i[OFF_W+1:2];
  assign idx_s     = bus.pc_i[OFF_W+IDX_W+1:OFF_W+2];
  assign tag_s     = bus.pc_i[31:OFF_W+IDX_W+2];
  assign pc_unused = ^bus.pc_i[1:0];

  state_e           state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [TG_W-1:0]  ltag_q, ltag_d;
  logic [IDX_W-1:0] lidx_q, lidx_d;
  logic             flush_pend_q, flush_pend_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;
  logic [TG_W-1:0]  tag_mem_q [LINES];

  logic             lookup_hit_s;
  logic             hit_s;
  logic             last_beat_s;
  logic             arr_we_s;
  logic             tag_we_s;
  logic [31:0]      rdata_s;

  assign lookup_hit_s = valid_q[idx_s] && (tag_mem_q[idx_s] == tag_s);
  assign hit_s        = (state_q == IDLE) && bus.req_i && !bus.flush_i && lookup_hit_s;
  assign last_beat_s  = (beat_q == OFF_W'(WORDS - 1));

  // next-state and refill control
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    beat_d       = beat_q;
    ltag_d       = ltag_q;
    lidx_d       = lidx_q;
    flush_pend_d = flush_pend_q;
    miss_cnt_d   = miss_cnt_q;
    arr_we_s     = 1'b0;
    tag_we_s     = 1'b0;
    hit_cnt_d    = hit_s ? sat_inc(hit_cnt_q) : hit_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          valid_d = '0;
        end else if (bus.req_i && !lookup_hit_s) begin
          state_d    = REFILL;
          ltag_d     = tag_s;
          lidx_d     = idx_s;
          beat_d     = '0;
          miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (bus.flush_i) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (bus.mem_ack_i) begin
          arr_we_s = 1'b1;
          beat_d   = beat_q + OFF_W'(1);
          if (last_beat_s) begin
            tag_we_s     = 1'b1;
            state_d      = IDLE;
            flush_pend_d = 1'b0;
            // a flush seen at any point of the refill also drops the new line
            if (flush_pend_q || bus.flush_i) begin
              valid_d = '0;
            end else begin
              valid_d[lidx_q] = 1'b1;
            end
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // control state with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      beat_q       <= '0;
      ltag_q       <= '0;
      lidx_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= 16'd0;
      miss_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      ltag_q       <= ltag_d;
      lidx_q       <= lidx_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // tag store, written once the last beat lands
  always_ff @(posedge clk_i) begin
    if (tag_we_s) begin
      tag_mem_q[lidx_q] <= ltag_q;
    end
  end

  icache_data_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_data (
    .clk_i   (clk_i),
    .we_i    (arr_we_s),
    .widx_i  (lidx_q),
    .woff_i  (beat_q),
    .wdata_i (bus.mem_data_i),
    .ridx_i  (idx_s),
    .roff_i  (off_s),
    .rdata_o (rdata_s)
  );

  assign bus.ready_o    = hit_s;
  assign bus.instr_o    = rdata_s;
  assign bus.mem_req_o  = (state_q == REFILL);
  assign bus.mem_addr_o = {ltag_q, lidx_q, beat_q, 2'b00};
  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: directed fetch/refill sequences push
// expected instructions and refill addresses; a monitor pops and compares.
module tb_instr_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_cache_if bus ();

  instr_cache #(
    .LINES (16),
    .WORDS (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_instr_q [$];
  logic [31:0] exp_addr_q  [$];

  localparam logic [31:0] A_BASE = 32'hA0A0_0000;
  localparam logic [31:0] B_BASE = 32'hB0B0_0000;
  localparam logic [31:0] C_BASE = 32'hC0C0_0000;
  localparam logic [31:0] D_BASE = 32'hD0D0_0000;
  localparam logic [31:0] E_BASE = 32'hE0E0_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every hit and every accepted beat is compared
  always @(negedge clk) begin
    if (!rst && bus.ready_o) begin
      if (exp_instr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_hit: ready_o=1 instr_o=%h with no hit expected", bus.instr_o);
      end else begin
        check("hit_instr", bus.instr_o, exp_instr_q.pop_front());
      end
    end
    if (!rst && bus.mem_req_o && bus.mem_ack_i) begin
      if (exp_addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: mem_addr_o=%h with no beat expected", bus.mem_addr_o);
      end else begin
        check("beat_addr", bus.mem_addr_o, exp_addr_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // request a missing pc; returns with the cache in REFILL
  task automatic miss_start(input logic [31:0] pc);
    bus.req_i = 1'b1;
    bus.pc_i  = pc;
    @(negedge clk);
    check("miss_ready", 32'(bus.ready_o), 32'd0);
    check("miss_memreq_idle", 32'(bus.mem_req_o), 32'd0);
    step();
    check("refill_memreq", 32'(bus.mem_req_o), 32'd1);
  endtask

  task automatic refill(input logic [31:0] base, input logic [31:0] dbase,
                        input int waits, input int flush_beat);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < waits; w++) begin
        bus.mem_ack_i = 1'b0;
        bus.flush_i   = 1'b0;
        @(negedge clk);
        check("wait_addr", bus.mem_addr_o, base + 32'(4 * b));
        check("wait_ready", 32'(bus.ready_o), 32'd0);
        step();
      end
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = dbase + 32'(b);
      bus.flush_i    = (b == flush_beat) ? 1'b1 : 1'b0;
      exp_addr_q.push_back(base + 32'(4 * b));
      step();
    end
    bus.mem_ack_i = 1'b0;
    bus.flush_i   = 1'b0;
    check("memreq_after_last", 32'(bus.mem_req_o), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_i      = 1'b0;
    bus.pc_i       = 32'd0;
    bus.flush_i    = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_memreq", 32'(bus.mem_req_o), 32'd0);
    check("rst_hits", 32'(bus.hit_cnt_o), 32'd0);
    check("rst_miss", 32'(bus.miss_cnt_o), 32'd0);
    step();
    rst = 1'b0;
    step();

    // cold miss, then two hits on the loaded line
    miss_start(32'h10);
    refill(32'h10, A_BASE, 0, -1);
    exp_instr_q.push_back(A_BASE);
    step();
    bus.pc_i = 32'h1C;
    exp_instr_q.push_back(A_BASE + 32'd3);
    step();
    bus.req_i = 1'b0;
    check("cold_miss_cnt", 32'(bus.miss_cnt_o), 32'd1);
    check("cold_hit_cnt", 32'(bus.hit_cnt_o), 32'd2);

    // conflict on index 1
    miss_start(32'h110);
    refill(32'h110, B_BASE, 0, -1);
    exp_instr_q.push_back(B_BASE);
    step();
    miss_start(32'h10);
    refill(32'h10, A_BASE, 0, -1);
    exp_instr_q.push_back(A_BASE);
    step();
    bus.req_i = 1'b0;
    check("conflict_miss_cnt", 32'(bus.miss_cnt_o), 32'd3);
    check("conflict_hit_cnt", 32'(bus.hit_cnt_o), 32'd4);

    // slow memory, pc in mid-line still refills from word 0
    miss_start(32'h24);
    refill(32'h20, C_BASE, 3, -1);
    exp_instr_q.push_back(C_BASE + 32'd1);
    step();
    bus.pc_i = 32'h28;
    exp_instr_q.push_back(C_BASE + 32'd2);
    step();
    bus.req_i = 1'b0;
    check("slow_miss_cnt", 32'(bus.miss_cnt_o), 32'd4);
    check("slow_hit_cnt", 32'(bus.hit_cnt_o), 32'd6);

    // flush during beat 2 clears old lines and the new one
    miss_start(32'h30);
    refill(32'h30, D_BASE, 0, 2);
    bus.req_i = 1'b0;
    step();
    miss_start(32'h10);
    refill(32'h10, A_BASE, 0, -1);
    exp_instr_q.push_back(A_BASE);
    step();
    miss_start(32'h30);
    refill(32'h30, D_BASE, 0, -1);
    exp_instr_q.push_back(D_BASE);
    step();
    bus.req_i = 1'b0;
    check("flushmid_miss_cnt", 32'(bus.miss_cnt_o), 32'd7);
    check("flushmid_hit_cnt", 32'(bus.hit_cnt_o), 32'd8);

    // flush in IDLE on a cached pc: no hit, no refill, then a miss
    bus.req_i   = 1'b1;
    bus.pc_i    = 32'h10;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_idle_ready", 32'(bus.ready_o), 32'd0);
    step();
    bus.flush_i = 1'b0;
    check("flush_idle_no_refill", 32'(bus.mem_req_o), 32'd0);
    check("flush_idle_miss_cnt", 32'(bus.miss_cnt_o), 32'd7);
    miss_start(32'h10);
    refill(32'h10, A_BASE, 0, -1);
    bus.req_i = 1'b0;
    check("flush_idle_miss_cnt2", 32'(bus.miss_cnt_o), 32'd8);
    check("flush_idle_hit_cnt", 32'(bus.hit_cnt_o), 32'd8);

    // asynchronous reset during beat 1
    miss_start(32'h40);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = E_BASE;
    exp_addr_q.push_back(32'h40);
    step();
    bus.mem_ack_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_memreq", 32'(bus.mem_req_o), 32'd0);
    check("async_rst_miss_cnt", 32'(bus.miss_cnt_o), 32'd0);
    step();
    rst = 1'b0;
    miss_start(32'h10);
    refill(32'h10, A_BASE, 0, -1);
    check("post_rst_miss_cnt", 32'(bus.miss_cnt_o), 32'd1);

    // hit counter saturation
    for (int i = 0; i < 65540; i++) begin
      exp_instr_q.push_back(A_BASE);
      step();
    end
    check("sat_hit_cnt", 32'(bus.hit_cnt_o), 32'h0000_FFFF);
    exp_instr_q.push_back(A_BASE);
    step();
    bus.req_i = 1'b0;
    check("sat_hit_hold", 32'(bus.hit_cnt_o), 32'h0000_FFFF);
    check("sat_miss_cnt", 32'(bus.miss_cnt_o), 32'd1);
    step();

    check("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
